// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Stall / bubble controller for a five-stage pipeline.
//               Mirrors the destination register and result-readiness (Tnew)
//               of the instructions in EX and MEM. Each cycle it compares them
//               against the source registers and use-deadlines (Tuse) of the
//               instruction in ID. While a hazard stands it freezes PC and
//               IF/ID and flushes a bubble into ID/EX. When the optional
//               multiply/divide-unit (MDU) tracking is built in, it also
//               holds MDU instructions in ID while the MDU is busy.
//
// Build option: HAZARD_MDU_STALL_EN
//               defined   -> E_md, md_cnt and the MDU hazard term are present;
//                            md_busy reflects md_cnt != 0.
//               undefined -> MDU tracking removed, md_busy tied to 0,
//                            ID_md_use / ID_md_start ignored.
//
// Parameters  : MULT_CYCLES  MDU busy cycles after a multiply starts (1..15)
//               DIV_CYCLES   MDU busy cycles after a divide starts   (1..15)
//
// Ports       : clk          clock, rising edge
//               reset        asynchronous, active-low; clears all state
//               ID_rs/ID_rt  source registers of the ID instruction
//               ID_Tuse_rs/rt cycles until operand consumed (3 = not read)
//               ID_A3        destination of the ID instruction (0 = none)
//               ID_Tnew      cycles after entering EX until forwardable
//               ID_md_use    ID instruction uses the MDU
//               ID_md_start  00 none, 01 multiply, 10 divide, 11 as 00
//               stall        hazard present this cycle (combinational)
//               PC_en        ~stall
//               IF_ID_en     ~stall
//               ID_EX_flush  stall
//               md_busy      MDU countdown non-zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [1:0] ID_Tuse_rs,
    input  logic [1:0] ID_Tuse_rt,
    input  logic [4:0] ID_A3,
    input  logic [1:0] ID_Tnew,
    input  logic       ID_md_use,
    input  logic [1:0] ID_md_start,
    output logic       stall,
    output logic       PC_en,
    output logic       IF_ID_en,
    output logic       ID_EX_flush,
    output logic       md_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_MD_NONE = 2'b00;
    localparam logic [1:0] c_MD_MULT = 2'b01;
    localparam logic [1:0] c_MD_DIV  = 2'b10;

    localparam logic [3:0] c_MULT_CYCLES = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CYCLES  = 4'(DIV_CYCLES);

    // The countdown is four bits wide; anything outside 1..15 would either
    // never mark the MDU busy or silently wrap.
    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
        $error("hazard_stall_ctrl: MULT_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("hazard_stall_ctrl: DIV_CYCLES must be in 1..15");
    end

    // ------------------------------------------------------------------------
    // Tracked pipeline state (EX and MEM mirrors)
    // ------------------------------------------------------------------------
    logic [4:0] E_A3_q,   E_A3_d;
    logic [1:0] E_Tnew_q, E_Tnew_d;
    logic [4:0] M_A3_q,   M_A3_d;
    logic [1:0] M_Tnew_q, M_Tnew_d;

    logic w_haz_rs;
    logic w_haz_rt;
    logic w_haz_md;
    logic w_stall;

    // ------------------------------------------------------------------------
    // Data hazard check for one source operand.
    // Register 0 is hardwired, so it never depends on anything. An operand
    // that is not read carries Tuse = 3, which can never be below a 2-bit
    // Tnew, so it drops out without a special case.
    // ------------------------------------------------------------------------
    function automatic logic f_src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == e_a3) && (tuse < e_tnew);
        hit_m = (src == m_a3) && (tuse < m_tnew);
        return (src != 5'd0) && (hit_e || hit_m);
    endfunction

    assign w_haz_rs = f_src_hazard(ID_rs, ID_Tuse_rs, E_A3_q, E_Tnew_q, M_A3_q, M_Tnew_q);
    assign w_haz_rt = f_src_hazard(ID_rt, ID_Tuse_rt, E_A3_q, E_Tnew_q, M_A3_q, M_Tnew_q);

    // All hazard sources collapse into one stall; overlapping data and MDU
    // hazards therefore cost a single cycle, not two.
    assign w_stall = w_haz_rs || w_haz_rt || w_haz_md;

    // ------------------------------------------------------------------------
    // Next-state for the EX/MEM mirrors
    // ------------------------------------------------------------------------
    always_comb begin
        // MEM inherits EX; its readiness moves one cycle closer, floored at 0
        // so an instruction that has reached WB can never cause a stall.
        M_A3_d   = E_A3_q;
        M_Tnew_d = (E_Tnew_q != 2'd0) ? (E_Tnew_q - 2'd1) : 2'd0;

        // A stall injects a bubble into EX, mirroring the ID/EX flush.
        if (w_stall) begin
            E_A3_d   = 5'd0;
            E_Tnew_d = 2'd0;
        end else begin
            E_A3_d   = ID_A3;
            E_Tnew_d = ID_Tnew;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_A3_q   <= 5'd0;
            E_Tnew_q <= 2'd0;
            M_A3_q   <= 5'd0;
            M_Tnew_q <= 2'd0;
        end else begin
            E_A3_q   <= E_A3_d;
            E_Tnew_q <= E_Tnew_d;
            M_A3_q   <= M_A3_d;
            M_Tnew_q <= M_Tnew_d;
        end
    end

    // ------------------------------------------------------------------------
    // Multiply/divide unit tracking
    // ------------------------------------------------------------------------
`ifdef HAZARD_MDU_STALL_EN
    logic [1:0] E_md_q,   E_md_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    always_comb begin
        // Only real start codes enter EX; 11 and bubbles both become "none".
        E_md_d = c_MD_NONE;
        if (!w_stall && ((ID_md_start == c_MD_MULT) || (ID_md_start == c_MD_DIV))) begin
            E_md_d = ID_md_start;
        end

        // The start in EX loads the countdown; a start arriving while the
        // counter is still running simply reloads it.
        md_cnt_d = md_cnt_q;
        if (E_md_q == c_MD_MULT) begin
            md_cnt_d = c_MULT_CYCLES;
        end else if (E_md_q == c_MD_DIV) begin
            md_cnt_d = c_DIV_CYCLES;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_md_q   <= c_MD_NONE;
            md_cnt_q <= 4'd0;
        end else begin
            E_md_q   <= E_md_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // A start sitting in EX has not loaded the counter yet, so it must block
    // MDU users on its own for that first cycle.
    assign w_haz_md = ID_md_use && ((E_md_q != c_MD_NONE) || (md_cnt_q != 4'd0));
    assign md_busy  = (md_cnt_q != 4'd0);
`else
    // MDU tracking not built: its inputs and the cycle counts have no effect.
    logic w_md_unused;
    assign w_md_unused = ^{ID_md_use, ID_md_start, c_MULT_CYCLES, c_DIV_CYCLES,
                           c_MD_MULT, c_MD_DIV};
    assign w_haz_md    = 1'b0;
    assign md_busy     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Pipeline register controls
    // ------------------------------------------------------------------------
    assign stall       = w_stall;
    assign PC_en       = ~w_stall;
    assign IF_ID_en    = ~w_stall;
    assign ID_EX_flush = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl. Directed vector
//               table for data hazards, hand sequences for reset and MDU
//               waits, and randomized traffic against a cycle-level model
//               that tracks issued instructions and MDU start times.
//               Honours HAZARD_MDU_STALL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;
`ifdef HAZARD_MDU_STALL_EN
    localparam bit c_MDU_ON = 1'b1;
`else
    localparam bit c_MDU_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] ID_rs, ID_rt, ID_A3;
    logic [1:0] ID_Tuse_rs, ID_Tuse_rt, ID_Tnew, ID_md_start;
    logic       ID_md_use;
    logic       stall, PC_en, IF_ID_en, ID_EX_flush, md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES(c_MULT),
        .DIV_CYCLES (c_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_Tuse_rs (ID_Tuse_rs),
        .ID_Tuse_rt (ID_Tuse_rt),
        .ID_A3      (ID_A3),
        .ID_Tnew    (ID_Tnew),
        .ID_md_use  (ID_md_use),
        .ID_md_start(ID_md_start),
        .stall      (stall),
        .PC_en      (PC_en),
        .IF_ID_en   (IF_ID_en),
        .ID_EX_flush(ID_EX_flush),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input bit exp_stall, input bit exp_busy);
        chk({tag, ".stall"},       int'(stall),       int'(exp_stall));
        chk({tag, ".PC_en"},       int'(PC_en),       int'(!exp_stall));
        chk({tag, ".IF_ID_en"},    int'(IF_ID_en),    int'(!exp_stall));
        chk({tag, ".ID_EX_flush"}, int'(ID_EX_flush), int'(exp_stall));
        chk({tag, ".md_busy"},     int'(md_busy),     int'(exp_busy));
    endtask

    task automatic set_id(input int rs, input int trs, input int rt, input int trt,
                          input int a3, input int tnew, input bit mduse, input int mdst);
        ID_rs       = 5'(rs);
        ID_Tuse_rs  = 2'(trs);
        ID_rt       = 5'(rt);
        ID_Tuse_rt  = 2'(trt);
        ID_A3       = 5'(a3);
        ID_Tnew     = 2'(tnew);
        ID_md_use   = mduse;
        ID_md_start = 2'(mdst);
    endtask

    task automatic set_nop();
        set_id(0, 3, 0, 3, 0, 0, 1'b0, 0);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: what was issued into EX and MEM, plus the cycle of the
    // most recent MDU start; busy-ness is plain cycle arithmetic.
    // ------------------------------------------------------------------------
    int m_ex_a3, m_ex_tnew, m_ex_start, m_mem_a3, m_mem_tnew;
    int m_cyc, m_last_start, m_last_len;
    bit m_have_start;

    task automatic model_reset();
        m_ex_a3 = 0; m_ex_tnew = 0; m_ex_start = 0;
        m_mem_a3 = 0; m_mem_tnew = 0;
        m_cyc = 0; m_last_start = 0; m_last_len = 0; m_have_start = 1'b0;
    endtask

    function automatic bit m_src_haz(input int src, input int tuse);
        int mem_left;
        mem_left = (m_mem_tnew > 0) ? m_mem_tnew - 1 : 0;
        if (src == 0) return 1'b0;
        return ((src == m_ex_a3) && (tuse < m_ex_tnew)) ||
               ((src == m_mem_a3) && (tuse < mem_left));
    endfunction

    function automatic bit m_busy();
        return c_MDU_ON && m_have_start && ((m_cyc - m_last_start) <= m_last_len);
    endfunction

    function automatic bit m_stall();
        bit md;
        md = c_MDU_ON && ID_md_use && ((m_ex_start != 0) || m_busy());
        return m_src_haz(int'(ID_rs), int'(ID_Tuse_rs)) ||
               m_src_haz(int'(ID_rt), int'(ID_Tuse_rt)) || md;
    endfunction

    task automatic model_advance(input bit st);
        if (m_ex_start != 0) begin
            m_have_start = 1'b1;
            m_last_start = m_cyc;
            m_last_len   = (m_ex_start == 1) ? c_MULT : c_DIV;
        end
        m_mem_a3   = m_ex_a3;
        m_mem_tnew = m_ex_tnew;
        if (st) begin
            m_ex_a3 = 0; m_ex_tnew = 0; m_ex_start = 0;
        end else begin
            m_ex_a3    = int'(ID_A3);
            m_ex_tnew  = int'(ID_Tnew);
            m_ex_start = !c_MDU_ON ? 0 : (ID_md_start == 2'b01) ? 1 :
                         (ID_md_start == 2'b10) ? 2 : 0;
        end
        m_cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Directed data-hazard table (one row per cycle, state carries over)
    // ------------------------------------------------------------------------
    typedef struct {
        int rs; int trs; int rt; int trt; int a3; int tnew; bit exp_stall;
    } vec_t;

    localparam int c_NVEC = 17;
    vec_t vecs[c_NVEC];

    function automatic vec_t mk(input int rs, input int trs, input int rt, input int trt,
                                input int a3, input int tnew, input bit st);
        vec_t v;
        v.rs = rs; v.trs = trs; v.rt = rt; v.trt = trt; v.a3 = a3; v.tnew = tnew;
        v.exp_stall = st;
        return v;
    endfunction

    // MDU wait: start in ID, then an MDU reader held in ID for a fixed window.
    task automatic run_mdu(input string name, input int code, input int exp_stalls,
                           input int exp_busy);
        int n_st, n_bz, first, last;
        n_st = 0; n_bz = 0; first = -1; last = -1;
        set_id(0, 3, 0, 3, 0, 0, 1'b1, code);
        @(negedge clk);
        chk({name, ".issue_stall"}, int'(stall), 0);
        @(posedge clk); #1;
        set_id(0, 3, 0, 3, 0, 0, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) begin
                n_st++;
                if (first < 0) first = i;
                last = i;
            end
            if (md_busy) n_bz++;
            @(posedge clk); #1;
        end
        chk({name, ".stall_cycles"}, n_st, exp_stalls);
        chk({name, ".busy_cycles"},  n_bz, exp_busy);
        chk({name, ".stall_span"},   (n_st > 0) ? (last - first + 1) : 0, exp_stalls);
        chk({name, ".stall_first"},  first, (exp_stalls > 0) ? 0 : -1);
        set_nop();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        bit exp_st;

        // load-use
        vecs[0]  = mk(0, 3, 0, 3, 8, 2, 1'b0);
        vecs[1]  = mk(8, 1, 0, 3, 9, 1, 1'b1);
        vecs[2]  = mk(8, 1, 0, 3, 9, 1, 1'b0);
        // $0 never stalls, even against a pending write to 0
        vecs[3]  = mk(0, 3, 0, 3, 0, 2, 1'b0);
        vecs[4]  = mk(0, 0, 0, 3, 0, 0, 1'b0);
        // unread rt (Tuse 3) against a Tnew 2 match
        vecs[5]  = mk(0, 3, 0, 3, 12, 2, 1'b0);
        vecs[6]  = mk(0, 3, 12, 3, 0, 0, 1'b0);
        // two-deep dependency on rt: two stall cycles
        vecs[7]  = mk(0, 3, 0, 3, 5, 2, 1'b0);
        vecs[8]  = mk(0, 3, 5, 0, 0, 0, 1'b1);
        vecs[9]  = mk(0, 3, 5, 0, 0, 0, 1'b1);
        vecs[10] = mk(0, 3, 5, 0, 0, 0, 1'b0);
        // rs hazard carried over into MEM
        vecs[11] = mk(0, 3, 0, 3, 6, 3, 1'b0);
        vecs[12] = mk(6, 1, 6, 3, 0, 0, 1'b1);
        vecs[13] = mk(6, 1, 6, 3, 0, 0, 1'b1);
        vecs[14] = mk(6, 1, 6, 3, 0, 0, 1'b0);
        // Tuse equal to Tnew is not a hazard
        vecs[15] = mk(0, 3, 0, 3, 7, 1, 1'b0);
        vecs[16] = mk(7, 1, 0, 3, 0, 0, 1'b0);

        set_nop();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset_held", 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_outs("reset_release", 1'b0, 1'b0);
        @(posedge clk); #1;

        // --- reset mid-countdown (divide loaded, counter at 7) ---
        set_id(0, 3, 0, 3, 0, 0, 1'b1, 2);
        @(posedge clk); #1;
        set_nop();
        repeat (4) @(posedge clk);
        #1;
        ID_md_use = 1'b1;
        #1;
        chk_outs("cnt7_before_reset", c_MDU_ON, c_MDU_ON);
        #1;
        reset = 1'b0;
        #1;
        chk_outs("cnt7_async_reset", 1'b0, 1'b0);
        @(posedge clk); #1;
        set_nop();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_outs($sformatf("after_reset[%0d]", i), 1'b0, 1'b0);
            @(posedge clk); #1;
        end

        // --- directed data-hazard table ---
        for (int i = 0; i < c_NVEC; i++) begin
            set_id(vecs[i].rs, vecs[i].trs, vecs[i].rt, vecs[i].trt,
                   vecs[i].a3, vecs[i].tnew, 1'b0, 0);
            @(negedge clk);
            chk_outs($sformatf("vec[%0d]", i), vecs[i].exp_stall, 1'b0);
            @(posedge clk); #1;
        end
        set_nop();
        @(posedge clk); #1;

        // --- MDU waits ---
        run_mdu("mult", 1, c_MDU_ON ? c_MULT + 1 : 0, c_MDU_ON ? c_MULT : 0);
        run_mdu("div",  2, c_MDU_ON ? c_DIV + 1  : 0, c_MDU_ON ? c_DIV  : 0);

        // --- randomized traffic against the model ---
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            set_id($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), 0);
            if (ID_md_use && ($urandom_range(0, 2) == 0))
                ID_md_start = 2'($urandom_range(0, 3));
            exp_st = m_stall();
            @(negedge clk);
            chk_outs($sformatf("rand[%0d]", i), exp_st, m_busy());
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                #1;
                chk_outs($sformatf("rand_reset[%0d]", i), 1'b0, 1'b0);
                @(posedge clk); #1;
                reset = 1'b1;
                model_reset();
            end else begin
                @(posedge clk);
                model_advance(exp_st);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Stall and bubble controller for the five-stage pipeline; it drives the PC, IF/ID and ID/EX register controls. It mirrors the destination register and result-readiness (Tnew) of the instructions in EX and MEM. Each cycle it compares those against the source registers and use-deadline (Tuse) of the instruction in ID. While a hazard stands, it freezes PC and IF/ID and flushes a bubble into ID/EX; it also holds multiply/divide-unit (MDU) instructions while the MDU is busy.

## Interface
Parameters:
- MULT_CYCLES, 5, MDU busy cycles after a multiply starts (1..15)
- DIV_CYCLES, 10, MDU busy cycles after a divide starts (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all internal state
- ID_rs  in  5  source register rs of the ID instruction
- ID_rt  in  5  source register rt of the ID instruction
- ID_Tuse_rs  in  2  cycles until rs is consumed; 3 = rs not read
- ID_Tuse_rt  in  2  same for rt
- ID_A3  in  5  destination register of the ID instruction; 0 = none
- ID_Tnew  in  2  cycles after entering EX until the result is forwardable
- ID_md_use  in  1  ID instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- ID_md_start  in  2  00 none, 01 multiply start, 10 divide start, 11 treated as 00
- stall  out  1  hazard present this cycle
- PC_en  out  1  = ~stall
- IF_ID_en  out  1  = ~stall
- ID_EX_flush  out  1  = stall
- md_busy  out  1  MDU countdown non-zero

## Operation
- Tracked state: E_A3[4:0], E_Tnew[1:0], E_md[1:0], M_A3[4:0], M_Tnew[1:0], md_cnt[3:0].
- Data hazard on rs: ID_rs != 0, and either of the following holds:
  - ID_rs == E_A3 and ID_Tuse_rs < E_Tnew
  - ID_rs == M_A3 and ID_Tuse_rs < M_Tnew
- Data hazard on rt: the same two conditions with ID_rt and ID_Tuse_rt.
- MDU hazard: ID_md_use and (E_md != 00 or md_cnt != 0).
- stall is the OR of all hazards. It is purely combinational from the current inputs and tracked state.
- Every clock edge (no enable; this block is never frozen):
  - M_A3 <= E_A3.
  - M_Tnew <= E_Tnew - 1, saturating at 0.
  - If stall: E_A3 <= 0, E_Tnew <= 0, E_md <= 00. This bubble mirrors the ID/EX flush.
  - Else: E_A3 <= ID_A3, E_Tnew <= ID_Tnew, E_md <= ID_md_start (11 becomes 00).
- MDU countdown, evaluated each edge in priority order:
  - If E_md == 01: md_cnt <= MULT_CYCLES.
  - Else if E_md == 10: md_cnt <= DIV_CYCLES.
  - Else if md_cnt != 0: md_cnt <= md_cnt - 1.
- A start while md_cnt != 0 reloads the counter. The ID-stage MDU stall prevents this in correct operation.
- MEM-stage Tnew saturates at 0, so the WB stage never causes a stall.

## Timing
- Reset (reset = 0, asynchronous): all tracked state goes to 0 immediately. Outputs are then stall = 0, PC_en = 1, IF_ID_en = 1, ID_EX_flush = 0, md_busy = 0. These hold until the first edge after release.
- Reset asserted mid-countdown: md_cnt clears at once, and the MDU stall drops in the same cycle.
- stall has zero-cycle latency from the ID inputs. Tracked state updates one edge later.
- Load-use case: lw (Tnew = 2) in EX with a dependent addu (Tuse = 1) in ID.
  - One stall cycle: the bubble enters EX, lw moves to MEM with M_Tnew = 1.
  - Next cycle Tuse 1 < 1 is false, so addu proceeds.
- MDU case: mult in EX at cycle t, mflo in ID.
  - Stall at t (E_md), then t+1..t+5 (md_cnt 5..1).
  - mflo proceeds at t+6: MULT_CYCLES + 1 stall cycles total.
  - A divide gives DIV_CYCLES + 1.
- Data and MDU hazards in the same cycle produce a single stall; there is no double counting.

## Configuration
- HAZARD_MDU_STALL_EN defined: E_md, md_cnt and the MDU hazard term are present, and md_busy reflects md_cnt != 0.
- HAZARD_MDU_STALL_EN undefined:
  - E_md and md_cnt are removed and md_busy is tied to 0.
  - ID_md_use and ID_md_start are ignored.
  - Only data hazards stall.

## Test plan
- Reset: drive reset = 0 mid-countdown with md_cnt = 7 -> md_busy = 0, stall = 0 and PC_en = 1 immediately. They stay so after release with no ID hazards.
- Load-use:
  - Stimulus: cycle 0 ID_A3 = 8, ID_Tnew = 2; cycle 1 ID_rs = 8, ID_Tuse_rs = 1.
  - Response: stall = 1 in cycle 1 only; ID_EX_flush = 1 in cycle 1 only; cycle 2 stall = 0.
- $0 and unused operands:
  - ID_rs = 0 against E_A3 = 0 with E_Tnew = 2 -> stall = 0.
  - ID_Tuse_rt = 3 with an rt match at Tnew = 2 -> stall = 0.
- Two-deep dependency:
  - Stimulus: E_A3 = 5, E_Tnew = 2 (for example an lw) and ID_rt = 5, ID_Tuse_rt = 0 (for example a beq).
  - Response: stall for exactly 2 cycles, until M_Tnew reaches 0.
- MDU: multiply start enters EX, then mfhi waits in ID -> stall high for 6 consecutive cycles and md_busy high for 5. With a divide: 11 and 10.
- Macro off: repeat the MDU test -> stall = 0 and md_busy = 0 throughout.
